// File: rtl/rob_if.sv
// Reorder buffer bundle: issue, rename, operand query,
// CDB writeback, commit and flush signals.
interface rob_if #(
  parameter int ROB_ADDR = 3
);
  logic                rdy_in;
  logic                issue_valid_in;
  logic [1:0]          issue_type_in;
  logic [4:0]          issue_rd_in;
  logic [31:0]         issue_pc_in;
  logic                issue_pred_in;
  logic [31:0]         issue_alt_pc_in;
  logic                issue_ready_out;
  logic                rf_issue_valid;
  logic [4:0]          rf_index;
  logic [ROB_ADDR-1:0] rf_new_dep;
  logic [ROB_ADDR-1:0] q1_idx_in;
  logic [ROB_ADDR-1:0] q2_idx_in;
  logic                q1_ready;
  logic                q2_ready;
  logic [31:0]         q1_val;
  logic [31:0]         q2_val;
  logic                alu_valid_in;
  logic [ROB_ADDR-1:0] alu_idx_in;
  logic [31:0]         alu_val_in;
  logic                alu_taken_in;
  logic                lsb_valid_in;
  logic [ROB_ADDR-1:0] lsb_idx_in;
  logic [31:0]         lsb_val_in;
  logic                commit_valid;
  logic [4:0]          cdb_regid;
  logic [31:0]         cdb_value;
  logic [ROB_ADDR-1:0] cdb_RoBindex;
  logic                store_commit_out;
  logic                rob_clear;
  logic [31:0]         redirect_pc;

  modport slave (
    input  rdy_in, issue_valid_in, issue_type_in,
    input  issue_rd_in, issue_pc_in, issue_pred_in,
    input  issue_alt_pc_in,
    input  q1_idx_in, q2_idx_in,
    input  alu_valid_in, alu_idx_in, alu_val_in,
    input  alu_taken_in,
    input  lsb_valid_in, lsb_idx_in, lsb_val_in,
    output issue_ready_out, rf_issue_valid,
    output rf_index, rf_new_dep,
    output q1_ready, q2_ready, q1_val, q2_val,
    output commit_valid, cdb_regid, cdb_value,
    output cdb_RoBindex, store_commit_out,
    output rob_clear, redirect_pc
  );

  modport master (
    output rdy_in, issue_valid_in, issue_type_in,
    output issue_rd_in, issue_pc_in, issue_pred_in,
    output issue_alt_pc_in,
    output q1_idx_in, q2_idx_in,
    output alu_valid_in, alu_idx_in, alu_val_in,
    output alu_taken_in,
    output lsb_valid_in, lsb_idx_in, lsb_val_in,
    input  issue_ready_out, rf_issue_valid,
    input  rf_index, rf_new_dep,
    input  q1_ready, q2_ready, q1_val, q2_val,
    input  commit_valid, cdb_regid, cdb_value,
    input  cdb_RoBindex, store_commit_out,
    input  rob_clear, redirect_pc
  );
endinterface

// File: rtl/rob_unit.sv
// In-order retiring reorder buffer with CDB capture,
// operand bypass and branch-mispredict flush.
module rob_unit #(
  parameter int ROB_ADDR = 3
) (
  input  logic clk_in,
  input  logic rst_in,
  rob_if.slave rob
);
  localparam int DEPTH = 1 << ROB_ADDR;
  localparam logic [ROB_ADDR:0] FULL_CNT =
    (ROB_ADDR + 1)'(DEPTH);
  localparam logic [1:0] T_BR = 2'd1;
  localparam logic [1:0] T_ST = 2'd2;

  typedef struct packed {
    logic        busy;
    logic        ready;
    logic [1:0]  typ;
    logic [4:0]  rd;
    logic        pred;
    logic        taken;
    logic [31:0] alt;
    logic [31:0] val;
  } ent_t;

  ent_t ent [DEPTH];

  logic [ROB_ADDR-1:0] head;
  logic [ROB_ADDR-1:0] tail;
  logic [ROB_ADDR:0]   count;

  logic full;
  logic issue_ok;
  logic head_ok;
  logic retire;
  logic mispredict;
  logic alu_wr;
  logic lsb_wr;
  logic a1, l1, a2, l2;

  // Control: full/accept/retire/flush decisions.
  always_comb begin
    full = (count == FULL_CNT);
    issue_ok = rob.issue_valid_in && !full
            && !rob.rob_clear && rob.rdy_in;
    head_ok = (count != '0) && ent[head].ready
           && !rob.rob_clear;
    retire = head_ok && rob.rdy_in;
    mispredict = retire && (ent[head].typ == T_BR)
              && (ent[head].taken != ent[head].pred);
    alu_wr = rob.alu_valid_in
          && ent[rob.alu_idx_in].busy;
    lsb_wr = rob.lsb_valid_in
          && ent[rob.lsb_idx_in].busy;
  end

  // Issue handshake, rename and commit port drive.
  always_comb begin
    rob.issue_ready_out = !full && !rob.rob_clear;
    rob.rf_issue_valid = issue_ok
      && (rob.issue_type_in != T_ST)
      && (rob.issue_rd_in != 5'd0);
    rob.rf_index = rob.issue_rd_in;
    rob.rf_new_dep = tail;
    rob.commit_valid = retire
      && (ent[head].typ != T_ST);
    rob.store_commit_out = head_ok
      && (ent[head].typ == T_ST);
    rob.cdb_regid = head_ok ? ent[head].rd : '0;
    rob.cdb_value = head_ok ? ent[head].val : '0;
    rob.cdb_RoBindex = head_ok ? head : '0;
  end

  // Operand queries with same-cycle CDB bypass.
  always_comb begin
    a1 = rob.alu_valid_in
      && (rob.alu_idx_in == rob.q1_idx_in)
      && ent[rob.q1_idx_in].busy;
    l1 = rob.lsb_valid_in
      && (rob.lsb_idx_in == rob.q1_idx_in)
      && ent[rob.q1_idx_in].busy;
    a2 = rob.alu_valid_in
      && (rob.alu_idx_in == rob.q2_idx_in)
      && ent[rob.q2_idx_in].busy;
    l2 = rob.lsb_valid_in
      && (rob.lsb_idx_in == rob.q2_idx_in)
      && ent[rob.q2_idx_in].busy;
    rob.q1_ready = ent[rob.q1_idx_in].ready || a1 || l1;
    rob.q2_ready = ent[rob.q2_idx_in].ready || a2 || l2;
    rob.q1_val = a1 ? rob.alu_val_in
               : l1 ? rob.lsb_val_in
               : ent[rob.q1_idx_in].val;
    rob.q2_val = a2 ? rob.alu_val_in
               : l2 ? rob.lsb_val_in
               : ent[rob.q2_idx_in].val;
  end

  // Buffer state: allocate, capture, retire, flush.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      rob.rob_clear <= 1'b0;
      rob.redirect_pc <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent[i] <= '0;
      end
    end else if (rob.rdy_in) begin
      rob.rob_clear <= 1'b0;
      if (mispredict) begin
        for (int i = 0; i < DEPTH; i++) begin
          ent[i].busy <= 1'b0;
          ent[i].ready <= 1'b0;
        end
        head <= '0;
        tail <= '0;
        count <= '0;
        rob.rob_clear <= 1'b1;
        rob.redirect_pc <= ent[head].alt;
      end else begin
        if (alu_wr) begin
          ent[rob.alu_idx_in].ready <= 1'b1;
          ent[rob.alu_idx_in].val <= rob.alu_val_in;
          ent[rob.alu_idx_in].taken <= rob.alu_taken_in;
        end
        if (lsb_wr) begin
          ent[rob.lsb_idx_in].ready <= 1'b1;
          ent[rob.lsb_idx_in].val <= rob.lsb_val_in;
        end
        if (retire) begin
          ent[head].busy <= 1'b0;
          ent[head].ready <= 1'b0;
          head <= head + 1'b1;
        end
        if (issue_ok) begin
          ent[tail].busy <= 1'b1;
          ent[tail].ready <= 1'b0;
          ent[tail].typ <= rob.issue_type_in;
          ent[tail].rd <= rob.issue_rd_in;
          ent[tail].pred <= rob.issue_pred_in;
          ent[tail].taken <= 1'b0;
          ent[tail].alt <= rob.issue_alt_pc_in;
          tail <= tail + 1'b1;
        end
        unique case ({issue_ok, retire})
          2'b10: count <= count + 1'b1;
          2'b01: count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end
endmodule
